// File: rtl/demux_pkg.sv
// demux_pkg: shared definitions for the demux_stream block.
//   CNT_W     - width of the optional per-channel transfer counters
//   sel_w()   - select width for a given channel count
//   slot_st_e - per-channel holding slot state
package demux_pkg;

  localparam int CNT_W = 16;

  function automatic int sel_w(input int nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_st_e;

endpackage

// File: rtl/demux_stream_if.sv
// demux_stream_if: producer-side and consumer-side stream signals of demux_stream.
//   i, sel, i_valid, i_ready : input stream (beat, destination, handshake)
//   y, y_valid, y_ready      : NCH output streams, channel k at y[k*DATA_W +: DATA_W]
//   sel_err                  : sticky out-of-range select flag
//   cnt                      : per-channel transfer counters (DEMUX_STREAM_CNT_EN only)
// Modports: slave = the demux itself, master = the driving environment.
interface demux_stream_if
  import demux_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = sel_w(NCH)
);

  logic [DATA_W-1:0]     i;
  logic [SEL_W-1:0]      sel;
  logic                  i_valid;
  logic                  i_ready;
  logic [NCH*DATA_W-1:0] y;
  logic [NCH-1:0]        y_valid;
  logic [NCH-1:0]        y_ready;
  logic                  sel_err;
`ifdef DEMUX_STREAM_CNT_EN
  logic [NCH*CNT_W-1:0]  cnt;
`endif

  modport slave (
    input  i, sel, i_valid, y_ready,
    output i_ready, y, y_valid, sel_err
`ifdef DEMUX_STREAM_CNT_EN
    , output cnt
`endif
  );

  modport master (
    output i, sel, i_valid, y_ready,
    input  i_ready, y, y_valid, sel_err
`ifdef DEMUX_STREAM_CNT_EN
    , input cnt
`endif
  );

endinterface

// File: rtl/demux_stream_slot.sv
// demux_stream_slot: one-entry holding register for a single output channel.
//   clk, rst : clock, synchronous active-high reset
//   load, d  : write strobe (only asserted when the slot can take a beat) and data
//   ready    : consumer accept
//   valid    : slot FULL
//   data     : held beat, stable while FULL and not accepted
//   cnt      : completed output transfers, wraps (DEMUX_STREAM_CNT_EN only)
//
// state | meaning
// EMPTY | no beat held, valid=0
// FULL  | beat held, valid=1
module demux_stream_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data
`ifdef DEMUX_STREAM_CNT_EN
  , output logic [CNT_W-1:0] cnt
`endif
);

  slot_st_e st, st_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= EMPTY;
      data <= '0;
    end else begin
      st <= st_n;
      if (load) data <= d;
    end
  end

  // A load while FULL is only possible when the held beat drains in the
  // same cycle, so the slot simply stays FULL with the new beat.
  always_comb begin
    st_n = st;
    unique case (st)
      EMPTY: if (load)           st_n = FULL;
      FULL:  if (ready && !load) st_n = EMPTY;
    endcase
  end

  assign valid = (st == FULL);

`ifdef DEMUX_STREAM_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (valid && ready) cnt <= cnt + 1'b1;
  end
`endif

endmodule

// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-NCH valid/ready stream demultiplexer.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : demux_stream_if.slave (input stream, NCH output streams, sel_err, cnt)
// Each channel owns a one-entry slot, so a stalled channel never blocks others.
// Beats with sel >= NCH are accepted, dropped and flagged on sel_err (sticky).
// Optional feature macro: DEMUX_STREAM_CNT_EN adds per-channel 16-bit
// transfer counters on bus.cnt.
module demux_stream
  import demux_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = sel_w(NCH)
) (
  input logic         clk,
  input logic         rst,
  demux_stream_if.slave bus
);

  logic [SEL_W-1:0]  sel_q;
  logic              rdy;
  logic              accept;
  logic [NCH-1:0]    load;
  logic              slot_valid [NCH];
  logic [DATA_W-1:0] slot_data  [NCH];
`ifdef DEMUX_STREAM_CNT_EN
  logic [CNT_W-1:0]  slot_cnt   [NCH];
`endif

  assign sel_q = bus.sel;

  // Out-of-range selects match no channel and keep rdy at 1 (drop path).
  always_comb begin
    rdy = 1'b1;
    for (int k = 0; k < NCH; k++)
      if (int'(sel_q) == k) rdy = ~slot_valid[k] | bus.y_ready[k];
  end

  assign bus.i_ready = rdy;
  assign accept      = bus.i_valid & rdy;

  always_comb begin
    load = '0;
    for (int k = 0; k < NCH; k++)
      load[k] = accept && (int'(sel_q) == k);
  end

  always_ff @(posedge clk) begin
    if (rst)                                bus.sel_err <= 1'b0;
    else if (accept && int'(sel_q) >= NCH)  bus.sel_err <= 1'b1;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_slot
    demux_stream_slot #(.DATA_W(DATA_W)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[g]),
      .d     (bus.i),
      .ready (bus.y_ready[g]),
      .valid (slot_valid[g]),
      .data  (slot_data[g])
`ifdef DEMUX_STREAM_CNT_EN
      , .cnt (slot_cnt[g])
`endif
    );
  end

  always_comb begin
    bus.y       = '0;
    bus.y_valid = '0;
    for (int k = 0; k < NCH; k++) begin
      bus.y[k*DATA_W +: DATA_W] = slot_data[k];
      bus.y_valid[k]            = slot_valid[k];
    end
  end

`ifdef DEMUX_STREAM_CNT_EN
  always_comb begin
    bus.cnt = '0;
    for (int k = 0; k < NCH; k++)
      bus.cnt[k*CNT_W +: CNT_W] = slot_cnt[k];
  end
`endif

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: self-checking bench for demux_stream (NCH=5, DATA_W=8).
// NCH=5 leaves select codes 5..7 out of range so the drop path is reachable.
// Optional feature macro: DEMUX_STREAM_CNT_EN enables the counter scenario.
module tb_demux_stream;
  import demux_pkg::*;

  localparam int NCH = 5;
  localparam int DW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux_stream_if #(.NCH(NCH), .DATA_W(DW)) bus ();

  demux_stream #(.NCH(NCH), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: each channel is a one-beat mailbox.
  bit          m_full [NCH];
  logic [DW-1:0] m_data [NCH];
  bit          m_err;
`ifdef DEMUX_STREAM_CNT_EN
  logic [15:0] m_cnt [NCH];
`endif

  function automatic bit m_rdy();
    int s;
    s = int'(bus.sel);
    if (s >= NCH) return 1'b1;
    return !m_full[s] || bus.y_ready[s];
  endfunction

  always @(posedge clk) begin : model
    bit acc;
    int s;
    acc = bus.i_valid && m_rdy();
    s   = int'(bus.sel);
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        m_full[k] = 1'b0;
        m_data[k] = '0;
`ifdef DEMUX_STREAM_CNT_EN
        m_cnt[k] = '0;
`endif
      end
      m_err = 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++)
        if (m_full[k] && bus.y_ready[k]) begin
          m_full[k] = 1'b0;
`ifdef DEMUX_STREAM_CNT_EN
          m_cnt[k] = m_cnt[k] + 16'd1;
`endif
        end
      if (acc) begin
        if (s < NCH) begin
          m_full[s] = 1'b1;
          m_data[s] = bus.i;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  task automatic drive(input logic v, input int s, input logic [DW-1:0] d,
                       input logic [NCH-1:0] yr);
    @(negedge clk);
    bus.i_valid = v;
    bus.sel     = s[2:0];
    bus.i       = d;
    bus.y_ready = yr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 0, 8'h00, '0);
    tick();
    tick();
    checks++;
    if (bus.y_valid !== 5'b0) begin
      failures++; $display("FAIL reset_y_valid got=%b exp=%b", bus.y_valid, 5'b0);
    end
    checks++;
    if (bus.y !== 40'h0) begin
      failures++; $display("FAIL reset_y got=%h exp=%h", bus.y, 40'h0);
    end
    checks++;
    if (bus.sel_err !== 1'b0) begin
      failures++; $display("FAIL reset_sel_err got=%b exp=0", bus.sel_err);
    end
    for (int s = 0; s < 8; s++) begin
      bus.sel = s[2:0];
      #1;
      checks++;
      if (bus.i_ready !== 1'b1) begin
        failures++; $display("FAIL reset_i_ready sel=%0d got=%b exp=1", s, bus.i_ready);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    drive(1'b1, 2, 8'hA1, '0);
    #1;
    checks++;
    if (bus.i_ready !== 1'b1) begin
      failures++; $display("FAIL basic_i_ready got=%b exp=1", bus.i_ready);
    end
    tick();
    checks++;
    if (bus.y_valid !== 5'b00100) begin
      failures++; $display("FAIL basic_y_valid got=%b exp=%b", bus.y_valid, 5'b00100);
    end
    checks++;
    if (bus.y !== 40'h00_00_A1_00_00) begin
      failures++; $display("FAIL basic_y got=%h exp=%h", bus.y, 40'h00_00_A1_00_00);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 1, 8'h11, '0);
    tick();
    checks++;
    if (bus.y_valid !== 5'b00110) begin
      failures++; $display("FAIL stall_load_y_valid got=%b exp=%b", bus.y_valid, 5'b00110);
    end
    drive(1'b1, 1, 8'h22, '0);
    #1;
    checks++;
    if (bus.i_ready !== 1'b0) begin
      failures++; $display("FAIL stall_i_ready got=%b exp=0", bus.i_ready);
    end
    tick();
    checks++;
    if (bus.y[15:8] !== 8'h11) begin
      failures++; $display("FAIL stall_hold_ch1 got=%h exp=11", bus.y[15:8]);
    end
    drive(1'b1, 3, 8'h33, '0);
    #1;
    checks++;
    if (bus.i_ready !== 1'b1) begin
      failures++; $display("FAIL stall_other_ready got=%b exp=1", bus.i_ready);
    end
    tick();
    checks++;
    if (bus.y_valid !== 5'b01110) begin
      failures++; $display("FAIL stall_other_y_valid got=%b exp=%b", bus.y_valid, 5'b01110);
    end
    checks++;
    if (bus.y[31:24] !== 8'h33 || bus.y[15:8] !== 8'h11) begin
      failures++;
      $display("FAIL stall_other_data got ch3=%h ch1=%h exp ch3=33 ch1=11", bus.y[31:24], bus.y[15:8]);
    end
  endtask

  task automatic test_back_to_back();
    for (int b = 1; b <= 8; b++) begin
      drive(1'b1, 0, b[7:0], 5'b00001);
      #1;
      checks++;
      if (bus.i_ready !== 1'b1) begin
        failures++; $display("FAIL b2b_i_ready beat=%0d got=%b exp=1", b, bus.i_ready);
      end
      tick();
      checks++;
      if (bus.y_valid[0] !== 1'b1 || bus.y[7:0] !== b[7:0]) begin
        failures++;
        $display("FAIL b2b_beat beat=%0d got v=%b d=%h exp v=1 d=%h", b, bus.y_valid[0], bus.y[7:0], b[7:0]);
      end
    end
    drive(1'b0, 0, 8'h00, 5'b00001);
    tick();
    checks++;
    if (bus.y_valid !== 5'b01110) begin
      failures++; $display("FAIL b2b_drain got=%b exp=%b", bus.y_valid, 5'b01110);
    end
  endtask

  task automatic test_sel_err();
    checks++;
    if (bus.sel_err !== 1'b0) begin
      failures++; $display("FAIL selerr_pre got=%b exp=0", bus.sel_err);
    end
    drive(1'b1, 6, 8'h5A, '0);
    #1;
    checks++;
    if (bus.i_ready !== 1'b1) begin
      failures++; $display("FAIL selerr_i_ready got=%b exp=1", bus.i_ready);
    end
    tick();
    checks++;
    if (bus.sel_err !== 1'b1 || bus.y_valid !== 5'b01110) begin
      failures++;
      $display("FAIL selerr_set got err=%b v=%b exp err=1 v=%b", bus.sel_err, bus.y_valid, 5'b01110);
    end
    drive(1'b0, 0, 8'h00, '0);
    repeat (3) tick();
    checks++;
    if (bus.sel_err !== 1'b1) begin
      failures++; $display("FAIL selerr_sticky got=%b exp=1", bus.sel_err);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 0, 8'h77, '0);
    tick();
    checks++;
    if (bus.y_valid[0] !== 1'b1 || bus.y_valid[2] !== 1'b1) begin
      failures++; $display("FAIL rstmid_pre got=%b exp ch0,ch2 full", bus.y_valid);
    end
    drive(1'b1, 4, 8'hEE, '0);
    rst = 1'b1;
    tick();
    checks++;
    if (bus.y_valid !== 5'b0 || bus.y !== 40'h0 || bus.sel_err !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_clear got v=%b y=%h err=%b exp v=0 y=0 err=0", bus.y_valid, bus.y, bus.sel_err);
    end
    drive(1'b0, 0, 8'h00, '0);
    rst = 1'b0;
  endtask

  task automatic test_random();
    bit          hold = 1'b0;
    logic        v = 1'b0;
    int          s = 0;
    logic [7:0]  d = '0;
    logic [NCH-1:0] yr;
    bit          exp_rdy;
    int          bad;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        v = ($urandom_range(0, 9) < 7);
        s = $urandom_range(0, 7);
        d = 8'($urandom);
      end
      yr = NCH'($urandom);
      drive(v, s, d, yr);
      #1;
      exp_rdy = m_rdy();
      checks++;
      if (bus.i_ready !== exp_rdy) begin
        failures++; $display("FAIL rand_i_ready cyc=%0d sel=%0d got=%b exp=%b", n, s, bus.i_ready, exp_rdy);
      end
      hold = v && !exp_rdy;
      tick();
      bad = 0;
      for (int k = 0; k < NCH; k++) begin
        if (bus.y_valid[k] !== m_full[k]) bad++;
        else if (m_full[k] && bus.y[k*DW +: DW] !== m_data[k]) bad++;
`ifdef DEMUX_STREAM_CNT_EN
        if (bus.cnt[k*16 +: 16] !== m_cnt[k]) bad++;
`endif
      end
      if (bus.sel_err !== m_err) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL rand_state cyc=%0d got v=%b y=%h err=%b exp err=%b (%0d fields differ)",
                 n, bus.y_valid, bus.y, bus.sel_err, m_err, bad);
      end
    end
    drive(1'b0, 0, 8'h00, '0);
  endtask

`ifdef DEMUX_STREAM_CNT_EN
  task automatic test_cnt();
    rst = 1'b1;
    drive(1'b0, 0, 8'h00, '0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 32'hFFFE; n++) begin
      drive(1'b1, 3, n[7:0], 5'b01000);
      tick();
    end
    drive(1'b0, 3, 8'h00, 5'b01000);
    tick();
    checks++;
    if (bus.cnt[63:48] !== 16'hFFFE) begin
      failures++; $display("FAIL cnt_preload got=%h exp=fffe", bus.cnt[63:48]);
    end
    drive(1'b1, 3, 8'hC1, 5'b01000);
    tick();
    drive(1'b0, 3, 8'h00, 5'b01000);
    tick();
    checks++;
    if (bus.cnt[63:48] !== 16'hFFFF) begin
      failures++; $display("FAIL cnt_ffff got=%h exp=ffff", bus.cnt[63:48]);
    end
    drive(1'b1, 3, 8'hC2, 5'b01000);
    tick();
    drive(1'b0, 3, 8'h00, 5'b01000);
    tick();
    checks++;
    if (bus.cnt[63:48] !== 16'h0000) begin
      failures++; $display("FAIL cnt_wrap got=%h exp=0000", bus.cnt[63:48]);
    end
    checks++;
    if (bus.cnt[47:0] !== 48'h0 || bus.cnt[79:64] !== 16'h0) begin
      failures++; $display("FAIL cnt_others got=%h exp other channels 0", bus.cnt);
    end
  endtask
`endif

  initial begin
    bus.i_valid = 1'b0;
    bus.sel     = '0;
    bus.i       = '0;
    bus.y_ready = '0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_sel_err();
    test_reset_mid();
    test_random();
`ifdef DEMUX_STREAM_CNT_EN
    test_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_stream.md
# demux_stream

Parametrised, registered 1-to-NCH stream demultiplexer. It is the successor of the 4-way combinational demux.

- Routes one `DATA_W` input beat to the output channel chosen by `sel`.
- Uses a valid/ready handshake on the input and on every output.
- Each output channel has its own one-entry holding register, so a stalled channel does not block traffic to other channels.
- Sits between a single producer and NCH independent consumers, for example a packet dispatcher in front of per-lane processing.

## Interface
Parameters:
- `NCH`, 4: number of output channels, 2..16. Need not be a power of 2.
- `DATA_W`, 8: beat width in bits, 1..64.
- `SEL_W`, `$clog2(NCH)`: select width. Derived; do not override.

Ports:
- `clk` in 1: single clock. All logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `i` in `DATA_W`: input beat.
- `sel` in `SEL_W`: destination channel. Sampled together with `i`.
- `i_valid` in 1: input beat present.
- `i_ready` out 1: block can accept. Combinational from `sel` and channel state.
- `y` out `NCH*DATA_W`: channel k data at `[k*DATA_W +: DATA_W]`.
- `y_valid` out `NCH`: per-channel beat present.
- `y_ready` in `NCH`: per-channel consumer accept.
- `sel_err` out 1: sticky flag, set when a beat with `sel >= NCH` is accepted.
- `cnt` out `NCH*16`: per-channel transfer counters. Present only when `DEMUX_STREAM_CNT_EN` is defined.

## Operation
- Input transfer occurs when `i_valid & i_ready` at a rising edge.
- Channel k output transfer occurs when `y_valid[k] & y_ready[k]`.
- Per-channel slot has two states, EMPTY (`y_valid[k]=0`) and FULL (`y_valid[k]=1`):
  - EMPTY -> FULL: input transfer with `sel==k`. Slot loads `i`.
  - FULL -> EMPTY: output transfer on k with no input transfer to k in the same cycle.
  - FULL -> FULL: output transfer on k and input transfer to k in the same cycle. Slot reloads `i`, giving full throughput of one beat per cycle per channel.
- `i_ready` depends on `sel`:
  - `sel<NCH`: `i_ready = ~y_valid[sel] | y_ready[sel]`.
  - `sel>=NCH`: `i_ready=1`. The beat is consumed and discarded, `sel_err` sets, and no channel changes state.
- Only one channel can be loaded per cycle. Any number of channels can drain in the same cycle.
- Slot data is stable while FULL and `y_ready[k]=0`; a producer cannot disturb a held beat.
- Input rules: `i` and `sel` must be held stable while `i_valid=1 & i_ready=0`. `i_valid` must not drop before the transfer completes.
- `sel_err` clears only on reset.
- `y` data of an EMPTY slot retains its last value. Benches must not check it.

## Timing
- Reset values: `y_valid=0`, `y=0`, `sel_err=0`, `cnt=0`. `i_ready` then evaluates to 1 for every `sel`.
- Reset asserted mid-operation discards all held beats at that edge. Transfers in the reset cycle are ignored.
- Latency: an input transfer at edge n gives `y_valid[k]=1` with the data, visible after edge n.
- The earliest consumer accept is at edge n+1.
- Backpressure path is combinational: `y_ready[sel]` -> `i_ready`, with no registered stage.
- `sel_err` rises in the cycle after the offending transfer.

## Configuration
- Macro: `DEMUX_STREAM_CNT_EN`.
- When defined:
  - Each channel has a 16-bit counter of completed output transfers. It increments on `y_valid[k] & y_ready[k]`, wraps 0xFFFF -> 0x0000, and resets to 0.
  - `cnt` is exposed.
- When undefined: no counter logic and no `cnt` port. All other behaviour is identical.

## Structure
- Package `demux_pkg` holds:
  - the `CNT_W=16` constant;
  - the select-width function `sel_w(nch)`;
  - the slot state enum `slot_st_e` {EMPTY, FULL}.
- Sub-module `demux_stream_slot`: one-entry register with a valid/ready handshake and an optional counter. It is instantiated NCH times through a generate loop.
- The top level holds only the select decode, the `i_ready` mux, and `sel_err`.

## Test plan
- Reset, then NCH=4, DATA_W=8: send 0xA1 with sel=2 -> `y_valid=4'b0100` and `y[23:16]=0xA1` one cycle later, other channels stay 0.
- Hold `y_ready[1]=0`: send 0x11 to ch1, then 0x22 to ch1 -> `i_ready=0` while sel=1. With sel=3, 0x33 is accepted and `y_valid[3]=1` while ch1 stays 0x11.
- Channel 0 back-to-back with `y_ready[0]=1`: stream 0x01..0x08 -> all 8 beats delivered in order on consecutive cycles, `i_ready` continuously 1.
- NCH=5, sel=6 with `i_valid=1` -> `i_ready=1`, beat dropped, `y_valid` unchanged, `sel_err=1` next cycle and held until `rst`.
- Assert `rst` while ch0 and ch2 are FULL and stalled -> next cycle `y_valid=0`, `y=0`, `sel_err=0`.
- With `DEMUX_STREAM_CNT_EN`: preload ch3 counter to 0xFFFE via 0xFFFE transfers (or force), then 2 transfers -> `cnt[63:48]` reads 0xFFFF then 0x0000, other counters unchanged.
